data_mem_unit: RTL and testbench
================================

Name: data_mem_unit

Overview:
Data-memory stage that consumes the datapath's ALUResult (address), WriteData (store data) and the instruction's funct3, and returns ReadData for the Result mux. It provides a word-organised RAM with byte-lane writes, sign/zero extension for loads, misalignment detection, and a small memory-mapped I/O window. Reads are combinational so the single-cycle core gets load data in the same cycle; all state updates occur on the rising clock edge.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit RAM words (power of two)
LED_W, 8, width of the LED output register

Ports:
clk  input  1  system clock
rst  input  1  reset; asynchronous, active-high
mem_read  input  1  load in this cycle
mem_write  input  1  store in this cycle
funct3  input  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
addr  input  32  byte address (ALUResult)
wdata  input  32  store data, right-aligned (rs2)
rdata  output  32  extended load data (to ReadData)
misalign_err  output  1  sticky access-error flag
cycle_count  output  32  free-running cycle counter
leds  output  LED_W  LED register

Behaviour:
- Reset values: misalign_err=0, cycle_count=0, leds=0. RAM contents are not reset. rdata is combinational and not registered.
- Decode: MMIO when addr[31:16]==16'hFFFF; otherwise RAM. RAM word index is addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so the RAM aliases (wraps) across the address space.
- Alignment: halfword access (funct3 001/101) requires addr[0]==0. Word access (010) requires addr[1:0]==0. Byte access is always aligned.
- Illegal access conditions:
  - mem_read or mem_write asserted with a misaligned address.
  - funct3 in {011,110,111}.
  - An MMIO access with funct3!=010.
  - funct3 100/101 together with mem_write.
- On an illegal access: no write occurs, rdata=0, and misalign_err is set at the next edge. The flag stays set until rst.
- RAM store: takes effect at the rising edge.
  - SB writes byte lane addr[1:0] with wdata[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - SW writes all 4 lanes.
  - Unselected lanes are unchanged.
- RAM load: combinational from the current array contents.
  - LB/LBU select byte lane addr[1:0] and sign- or zero-extend it.
  - LH/LHU select halfword addr[1] and sign- or zero-extend it.
  - LW returns the whole word.
- When mem_read=0: rdata=0.
- When mem_read and mem_write are both 1: rdata shows pre-write contents and the write commits at the edge.
- MMIO map (word access only):
  - 0xFFFF_0000 CYCLE: read returns cycle_count (the value before this edge); writes are ignored with no error.
  - 0xFFFF_0004 LED: read returns zero-extended leds; a write loads wdata[LED_W-1:0] at the edge.
  - Any other MMIO address reads 0; writes are ignored with no error.
- cycle_count increments by 1 on every clock edge when not in reset and wraps from 0xFFFF_FFFF to 0.
- Asynchronous reset mid-operation clears the registers immediately. A store coinciding with the reset edge is dropped for the LED register; it may or may not land in RAM, and tests must not depend on either outcome.

Decomposition:
- Shared package holds:
  - funct3 encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - MMIO_BASE=32'hFFFF_0000, MMIO_CYCLE_OFS=0, MMIO_LED_OFS=4.
- One combinational sub-module, dmem_lane_align. It produces byte-enables and lane-shifted write data from funct3/addr/wdata, and extracts and extends load data from the raw word. The top level owns the RAM, decode, counter, LED register and error flag.

Test Plan:
- Reset: assert rst, then release -> cycle_count=0, leds=0, misalign_err=0; after 5 clocks cycle_count=5.
- Byte lanes: SW 0x11223344 @0x10; SB 0xAA @0x12 -> LW @0x10 returns 0x11AA3344; LB @0x12 returns 0xFFFFFFAA; LBU @0x12 returns 0x000000AA.
- Halfwords: SH 0x8001 @0x22 -> LH @0x22 returns 0xFFFF8001; LHU returns 0x00008001; LW @0x20 has bits [31:16]=0x8001 and the lower half is unchanged.
- Misalignment: SW 0xDEADBEEF @0x31 -> no RAM change at 0x30, misalign_err=1 after the edge and still 1 after 10 clocks; LH @0x05 -> rdata=0.
- MMIO: SW 0x1A5 @0xFFFF0004 -> leds=0xA5; LW @0xFFFF0004 returns 0xA5; LB @0xFFFF0000 -> rdata=0 and misalign_err=1; SW @0xFFFF0000 leaves the counter unaffected.
- Aliasing/wrap: with DEPTH_WORDS=1024, SW 0x5 @0x0 -> LW @0x1000 returns 0x5. Force cycle_count to 0xFFFFFFFE via a long run or a bench-only hierarchical force on the counter register -> two clocks later it reads 0.

Source files
------------

// File: rtl/data_mem_unit_pkg.sv
// Shared definitions for the data-memory stage.
// Contents: funct3 access encodings, MMIO address map, access-size
// classification and alignment helpers used by data_mem_unit and
// dmem_lane_align.
package data_mem_unit_pkg;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD,
        SZ_BAD
    } access_size_e;

    localparam logic [31:0] MMIO_BASE      = 32'hFFFF_0000;
    localparam logic [15:0] MMIO_CYCLE_OFS = 16'h0000;
    localparam logic [15:0] MMIO_LED_OFS   = 16'h0004;

    function automatic access_size_e size_of(input logic [2:0] f3);
        access_size_e sz;
        case (f3)
            F3_B, F3_BU: sz = SZ_BYTE;
            F3_H, F3_HU: sz = SZ_HALF;
            F3_W:        sz = SZ_WORD;
            default:     sz = SZ_BAD;
        endcase
        return sz;
    endfunction

    function automatic logic is_aligned(input access_size_e sz, input logic [1:0] lo);
        logic ok;
        case (sz)
            SZ_HALF: ok = (lo[0] == 1'b0);
            SZ_WORD: ok = (lo == 2'b00);
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering for the data memory.
// Ports:
//   funct3     access size/sign
//   addr_lo    byte offset within the word (addr[1:0])
//   wdata      right-aligned store data
//   rword      raw 32-bit word read from RAM
//   byte_en    per-lane write enables
//   wdata_lane store data replicated onto every lane it may target
//   load_data  selected and sign/zero-extended load value
module dmem_lane_align
    import data_mem_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_lane,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Store data is replicated across lanes; byte_en picks which land.
    always_comb begin
        byte_en    = '0;
        wdata_lane = '0;
        case (size_of(funct3))
            SZ_BYTE: begin
                byte_en    = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
            end
            SZ_WORD: begin
                byte_en    = 4'b1111;
                wdata_lane = wdata;
            end
            default: begin
                byte_en    = '0;
                wdata_lane = '0;
            end
        endcase
    end

    always_comb begin
        byte_sel  = rword[{addr_lo, 3'b000} +: 8];
        half_sel  = addr_lo[1] ? rword[31:16] : rword[15:0];
        load_data = '0;
        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {24'h0, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data = {16'h0, half_sel};
            F3_W:    load_data = rword;
            default: load_data = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_unit.sv
// Data-memory stage: word-organised RAM with byte-lane writes, load
// extension, access-error detection and a small MMIO window.
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   mem_read      load this cycle
//   mem_write     store this cycle
//   funct3        access size/sign
//   addr          byte address
//   wdata         right-aligned store data
//   rdata         combinational, extended load data
//   misalign_err  sticky illegal-access flag
//   cycle_count   free-running cycle counter
//   leds          LED register
module data_mem_unit
    import data_mem_unit_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LED_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [2:0]       funct3,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             misalign_err,
    output logic [31:0]      cycle_count,
    output logic [LED_W-1:0] leds
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    logic [31:0]      mem [DEPTH_WORDS];
    logic [AW-1:0]    word_idx;
    logic [31:0]      rword;
    logic [3:0]       byte_en;
    logic [31:0]      wdata_lane;
    logic [31:0]      load_data;

    logic             is_mmio;
    logic             is_cycle_reg;
    logic             is_led_reg;
    logic             access;
    logic             illegal;
    logic             ram_we;
    logic             led_we;

    logic [31:0]      cycle_q;
    logic [LED_W-1:0] led_q;
    logic             err_q;

    // Upper address bits are dropped, so the RAM aliases across the space.
    assign word_idx = addr[AW+1:2];
    assign rword    = mem[word_idx];

    dmem_lane_align u_align (
        .funct3     (funct3),
        .addr_lo    (addr[1:0]),
        .wdata      (wdata),
        .rword      (rword),
        .byte_en    (byte_en),
        .wdata_lane (wdata_lane),
        .load_data  (load_data)
    );

    always_comb begin
        is_mmio      = (addr[31:16] == MMIO_BASE[31:16]);
        is_cycle_reg = is_mmio && (addr[15:0] == MMIO_CYCLE_OFS);
        is_led_reg   = is_mmio && (addr[15:0] == MMIO_LED_OFS);
        access       = mem_read || mem_write;
        illegal      = access && (
                           (size_of(funct3) == SZ_BAD)
                        || !is_aligned(size_of(funct3), addr[1:0])
                        || (is_mmio && (funct3 != F3_W))
                        || (mem_write && ((funct3 == F3_BU) || (funct3 == F3_HU))));
        ram_we       = mem_write && !illegal && !is_mmio;
        led_we       = mem_write && !illegal && is_led_reg;
    end

    always_comb begin
        rdata = '0;
        if (mem_read && !illegal) begin
            if (is_mmio) begin
                if (is_cycle_reg)
                    rdata = cycle_q;
                else if (is_led_reg)
                    rdata = 32'(led_q);
                else
                    rdata = '0;
            end else begin
                rdata = load_data;
            end
        end
    end

    // RAM has no reset; byte enables gate each lane independently.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (byte_en[i])
                    mem[word_idx][8*i +: 8] <= wdata_lane[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_q <= '0;
            led_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (led_we)
                led_q <= wdata[LED_W-1:0];
            if (illegal)
                err_q <= 1'b1;
        end
    end

    assign cycle_count  = cycle_q;
    assign leds         = led_q;
    assign misalign_err = err_q;

endmodule

// File: tb/tb_data_mem_unit.sv
// Scoreboard bench for data_mem_unit: the stimulus process drives an access
// just after a rising edge and queues the expected outputs; the monitor
// pops and compares everything queued at the following falling edge.
module tb_data_mem_unit;

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        misalign_err;
    logic [31:0] cycle_count;
    logic [7:0]  leds;

    data_mem_unit #(.DEPTH_WORDS(1024), .LED_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .funct3       (funct3),
        .addr         (addr),
        .wdata        (wdata),
        .rdata        (rdata),
        .misalign_err (misalign_err),
        .cycle_count  (cycle_count),
        .leds         (leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int { K_RDATA, K_LEDS, K_ERR, K_CYCLE } kind_e;

    typedef struct {
        string       name;
        kind_e       kind;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] tb_cyc;

    // Reference cycle counter kept by the bench itself.
    always @(posedge clk or posedge rst) begin
        if (rst) tb_cyc <= '0;
        else     tb_cyc <= tb_cyc + 32'd1;
    end

    // Monitor: compare every queued expectation at the falling edge.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e = sb.pop_front();
            case (e.kind)
                K_RDATA: act = rdata;
                K_LEDS:  act = {24'h0, leds};
                K_ERR:   act = {31'h0, misalign_err};
                default: act = cycle_count;
            endcase
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got 0x%08h, expected 0x%08h", e.name, act, e.exp);
            end
        end
    end

    task automatic expect_val(input string name, input kind_e kind, input logic [31:0] v);
        exp_t e;
        e.name = name;
        e.kind = kind;
        e.exp  = v;
        sb.push_back(e);
    endtask

    task automatic op(input logic rd, input logic wr, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd);
        mem_read  = rd;
        mem_write = wr;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
    endtask

    task automatic idle();
        op(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state and counting
        expect_val("rst_cycle", K_CYCLE, 32'd0);
        expect_val("rst_leds",  K_LEDS,  32'd0);
        expect_val("rst_err",   K_ERR,   32'd0);
        repeat (5) step();
        expect_val("cycle_after_5", K_CYCLE, 32'd5);

        // Byte lanes
        op(1'b0, 1'b1, 3'b010, 32'h10, 32'h1122_3344); step();
        op(1'b0, 1'b1, 3'b000, 32'h12, 32'h0000_00AA); step();
        op(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        expect_val("lw_after_sb", K_RDATA, 32'h11AA_3344); step();
        op(1'b1, 1'b0, 3'b000, 32'h12, 32'h0);
        expect_val("lb_sext", K_RDATA, 32'hFFFF_FFAA); step();
        op(1'b1, 1'b0, 3'b100, 32'h12, 32'h0);
        expect_val("lbu_zext", K_RDATA, 32'h0000_00AA); step();
        op(1'b1, 1'b0, 3'b000, 32'h10, 32'h0);
        expect_val("lb_lane0", K_RDATA, 32'h0000_0044); step();

        // Halfwords
        op(1'b0, 1'b1, 3'b010, 32'h20, 32'h5566_7788); step();
        op(1'b0, 1'b1, 3'b001, 32'h22, 32'h0000_8001); step();
        op(1'b1, 1'b0, 3'b001, 32'h22, 32'h0);
        expect_val("lh_sext", K_RDATA, 32'hFFFF_8001); step();
        op(1'b1, 1'b0, 3'b101, 32'h22, 32'h0);
        expect_val("lhu_zext", K_RDATA, 32'h0000_8001); step();
        op(1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
        expect_val("lw_after_sh", K_RDATA, 32'h8001_7788); step();

        // Aliasing
        op(1'b0, 1'b1, 3'b010, 32'h0, 32'h5); step();
        op(1'b1, 1'b0, 3'b010, 32'h1000, 32'h0);
        expect_val("alias_lw", K_RDATA, 32'h5); step();

        // Read and write together: read shows pre-write data
        op(1'b0, 1'b1, 3'b010, 32'h30, 32'h0102_0304); step();
        op(1'b1, 1'b1, 3'b010, 32'h30, 32'hCAFE_F00D);
        expect_val("rw_prewrite", K_RDATA, 32'h0102_0304); step();
        op(1'b1, 1'b0, 3'b010, 32'h30, 32'h0);
        expect_val("rw_committed", K_RDATA, 32'hCAFE_F00D); step();
        op(1'b0, 1'b0, 3'b010, 32'h30, 32'h0);
        expect_val("no_read_zero", K_RDATA, 32'h0); step();

        // MMIO
        op(1'b0, 1'b1, 3'b010, 32'hFFFF_0004, 32'h0000_01A5); step();
        op(1'b1, 1'b0, 3'b010, 32'hFFFF_0004, 32'h0);
        expect_val("leds_written", K_LEDS,  32'hA5);
        expect_val("led_readback", K_RDATA, 32'hA5); step();
        op(1'b0, 1'b1, 3'b010, 32'hFFFF_0000, 32'h1234_5678); step();
        op(1'b1, 1'b0, 3'b010, 32'hFFFF_0000, 32'h0);
        expect_val("cycle_unaffected", K_CYCLE, tb_cyc);
        expect_val("cycle_read",       K_RDATA, tb_cyc);
        expect_val("mmio_no_err",      K_ERR,   32'd0); step();
        op(1'b1, 1'b0, 3'b010, 32'hFFFF_0008, 32'h0);
        expect_val("mmio_other_zero", K_RDATA, 32'h0); step();

        // Misalignment
        op(1'b0, 1'b1, 3'b010, 32'h31, 32'hDEAD_BEEF);
        expect_val("err_before_edge", K_ERR, 32'd0); step();
        op(1'b1, 1'b0, 3'b010, 32'h30, 32'h0);
        expect_val("misalign_no_write", K_RDATA, 32'hCAFE_F00D);
        expect_val("err_set",           K_ERR,   32'd1); step();
        op(1'b1, 1'b0, 3'b001, 32'h05, 32'h0);
        expect_val("lh_misaligned_zero", K_RDATA, 32'h0); step();
        idle();
        repeat (10) step();
        expect_val("err_sticky", K_ERR, 32'd1);
        step();

        // Asynchronous reset mid-run, then non-word MMIO access
        #2;
        rst = 1'b1;
        expect_val("mid_rst_leds",  K_LEDS,  32'd0);
        expect_val("mid_rst_err",   K_ERR,   32'd0);
        expect_val("mid_rst_cycle", K_CYCLE, 32'd0);
        step();
        rst = 1'b0;
        op(1'b1, 1'b0, 3'b000, 32'hFFFF_0000, 32'h0);
        expect_val("mmio_lb_zero", K_RDATA, 32'h0); step();
        idle();
        expect_val("mmio_lb_err", K_ERR, 32'd1); step();

        // Counter wrap
        force dut.cycle_q = 32'hFFFF_FFFE;
        #1;
        release dut.cycle_q;
        expect_val("cycle_forced", K_CYCLE, 32'hFFFF_FFFE); step();
        expect_val("cycle_max",    K_CYCLE, 32'hFFFF_FFFF); step();
        expect_val("cycle_wrap",   K_CYCLE, 32'h0000_0000); step();

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 5 && sb.size() > 0; i++) step();
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
